// File: rtl/nn_layer_engine.sv
// rtl/nn_layer_engine.sv - one layer pass: fetch image, then per neuron fetch coefficients, MAC, bias, ReLU, shift, saturate
`timescale 1ns/1ps
module nn_layer_engine #(
    parameter int IMBITS  = 6,
    parameter int CBITS   = 11,
    parameter int LBITS   = 2,
    parameter int NEURONS = 8,
    localparam int IW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LBITS-1:0]      layer_sel,
    output logic                  get_image,
    output logic                  get_coeffs,
    output logic [LBITS-1:0]      layer,
    input  logic                  busy,
    input  logic [IMBITS*8-1:0]   image_data,
    input  logic [CBITS*8-1:0]    coeff_data,
    output logic [7:0]            result_data,
    output logic [IW-1:0]         result_idx,
    output logic                  result_valid,
    output logic                  engine_busy,
    output logic                  done
);

    localparam int BW = (IMBITS > 1) ? $clog2(IMBITS) : 1;
    localparam int AW = 17 + $clog2(IMBITS);
    localparam int CW = (IMBITS + 2) * 8;

    typedef enum logic [3:0] {
        IDLE, REQ_IMG, WAIT_IMG, REQ_COEF, WAIT_COEF, MAC, FINISH, EMIT, DONE
    } state_t;

    state_t                  state, next_state;
    logic [IMBITS*8-1:0]     img_r;
    logic [CW-1:0]           coef_r;
    logic signed [AW-1:0]    acc;
    logic [BW-1:0]           byte_idx;
    logic [IW-1:0]           n_idx;
    logic                    seen_busy;

    logic [7:0]              img_byte, w_byte, bias;
    logic [3:0]              shift;
    logic signed [16:0]      prod;
    logic signed [AW-1:0]    prod_ext;
    logic [AW:0]             sum, relu, shifted;
    logic [7:0]              fin_value;
    logic                    mac_last, neuron_last, data_ready;
    logic                    unused_bits;

    assign img_byte    = img_r[8*byte_idx +: 8];
    assign w_byte      = coef_r[8*byte_idx +: 8];
    assign bias        = coef_r[IMBITS*8 +: 8];
    assign shift       = coef_r[(IMBITS+1)*8 +: 4];
    assign prod        = $signed({1'b0, img_byte}) * $signed(w_byte);
    assign prod_ext    = {{(AW-17){prod[16]}}, prod};
    assign mac_last    = (byte_idx == BW'(IMBITS - 1));
    assign neuron_last = (n_idx == IW'(NEURONS - 1));
    // Bus data is valid only on the first idle cycle after it has been seen busy.
    assign data_ready  = !busy && seen_busy;
    assign unused_bits = ^{coeff_data >> CW, coef_r[CW-4 +: 4]};

    // After ReLU the value is non-negative, so a logical shift matches the arithmetic one.
    assign sum       = {acc[AW-1], acc} + {{(AW-7){bias[7]}}, bias};
    assign relu      = sum[AW] ? '0 : sum;
    assign shifted   = relu >> shift;
    assign fin_value = (|shifted[AW:8]) ? 8'hFF : shifted[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        get_image    = 1'b0;
        get_coeffs   = 1'b0;
        result_valid = 1'b0;
        done         = 1'b0;
        engine_busy  = (state != IDLE);
        case (state)
            IDLE:      if (start) next_state = REQ_IMG;
            REQ_IMG:   if (!busy) begin
                           get_image  = 1'b1;
                           next_state = WAIT_IMG;
                       end
            WAIT_IMG:  if (data_ready) next_state = REQ_COEF;
            REQ_COEF:  if (!busy) begin
                           get_coeffs = 1'b1;
                           next_state = WAIT_COEF;
                       end
            WAIT_COEF: if (data_ready) next_state = MAC;
            MAC:       if (mac_last) next_state = FINISH;
            FINISH:    next_state = EMIT;
            EMIT: begin
                result_valid = 1'b1;
                next_state   = neuron_last ? DONE : REQ_COEF;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            img_r       <= '0;
            coef_r      <= '0;
            acc         <= '0;
            byte_idx    <= '0;
            n_idx       <= '0;
            seen_busy   <= 1'b0;
            layer       <= '0;
            result_data <= '0;
            result_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    layer <= layer_sel;
                    n_idx <= '0;
                end
                REQ_IMG, REQ_COEF: if (!busy) seen_busy <= 1'b0;
                WAIT_IMG: begin
                    if (busy)            seen_busy <= 1'b1;
                    else if (seen_busy)  img_r     <= image_data;
                end
                WAIT_COEF: begin
                    if (busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        coef_r   <= coeff_data[CW-1:0];
                        acc      <= '0;
                        byte_idx <= '0;
                    end
                end
                MAC: begin
                    acc      <= acc + prod_ext;
                    byte_idx <= byte_idx + 1'b1;
                end
                FINISH: begin
                    result_data <= fin_value;
                    result_idx  <= n_idx;
                end
                EMIT: if (!neuron_last) n_idx <= n_idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_engine.sv
// tb/tb_nn_layer_engine.sv - scoreboard bench for nn_layer_engine with a 3-cycle busy bus model
`timescale 1ns/1ps
module tb_nn_layer_engine;

    localparam int BUS_LAT = 3;

    logic        clk, reset, start;
    logic [1:0]  layer_sel, layer;
    logic        get_image, get_coeffs, busy, bus_busy, hold_busy;
    logic [47:0] image_data;
    logic [87:0] coeff_data;
    logic [7:0]  result_data;
    logic [2:0]  result_idx;
    logic        result_valid, engine_busy, done;

    int checks = 0;
    int errors = 0;
    int img_cnt = 0, coef_cnt = 0, res_cnt = 0;
    logic [1:0]  exp_layer = 2'd0;

    logic [47:0] img_q[$];
    logic [87:0] coef_q[$];
    logic [10:0] exp_q[$];

    logic [87:0] cs_a[8], cs_b[8], cs_c[8];
    logic [7:0]  ex_a[8], ex_b[8], ex_c[8];

    assign busy = bus_busy | hold_busy;

    nn_layer_engine dut (
        .clk(clk), .reset(reset), .start(start), .layer_sel(layer_sel),
        .get_image(get_image), .get_coeffs(get_coeffs), .layer(layer),
        .busy(busy), .image_data(image_data), .coeff_data(coeff_data),
        .result_data(result_data), .result_idx(result_idx),
        .result_valid(result_valid), .engine_busy(engine_busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, got, got, want, want, $time);
        end
    endtask

    function automatic logic [47:0] rep(input logic [7:0] x);
        return {6{x}};
    endfunction

    // Ignored bytes and the upper shift nibble carry junk on purpose.
    function automatic logic [87:0] cset(input logic [47:0] w, input logic [7:0] b, input logic [3:0] s);
        return {24'hA5C35A, 4'hA, s, b, w};
    endfunction

    // Bus model: busy for BUS_LAT cycles after each request, data valid as busy falls.
    initial begin
        bus_busy   = 1'b0;
        image_data = '0;
        coeff_data = '0;
        forever begin
            @(negedge clk);
            if (!reset && (get_image || get_coeffs)) begin
                automatic logic is_img = get_image;
                @(posedge clk);
                #1 bus_busy = 1'b1;
                repeat (BUS_LAT) @(posedge clk);
                #1 bus_busy = 1'b0;
                if (is_img) begin
                    if (img_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_get_image at %0t", $time);
                    end else image_data = img_q.pop_front();
                end else begin
                    if (coef_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_get_coeffs at %0t", $time);
                    end else coeff_data = coef_q.pop_front();
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every result pulse and checks pulse relationships.
    initial begin
        automatic logic       prev_valid = 1'b0;
        automatic logic [2:0] prev_idx = '0;
        automatic logic       prev_busy = 1'b0;
        automatic logic       coef_pend = 1'b0;
        automatic int         lat = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                coef_pend = 1'b0;
            end else begin
                if (get_coeffs) coef_pend = 1'b1;
                if (coef_pend && !busy && prev_busy) begin
                    coef_pend = 1'b0;
                    lat = 0;
                end else lat++;
                if (result_valid) begin
                    res_cnt++;
                    check("result_latency", lat, 8);
                    check("layer_held", layer, exp_layer);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result idx %0d data %0d", result_idx, result_data);
                    end else check("result_idx_data", {result_idx, result_data}, exp_q.pop_front());
                end
                if (done) check("done_after_last", {prev_valid, prev_idx}, {1'b1, 3'd7});
                if (get_image && get_coeffs) check("get_exclusive", 2'b11, 2'b00);
                if (get_image)  img_cnt++;
                if (get_coeffs) coef_cnt++;
            end
            prev_valid = result_valid;
            prev_idx   = result_idx;
            prev_busy  = busy;
        end
    end

    task automatic load_pass(input logic [47:0] img, input logic [87:0] c[8], input logic [7:0] e[8], input int nexp);
        img_q.push_back(img);
        for (int i = 0; i < 8; i++) begin
            coef_q.push_back(c[i]);
            if (i < nexp) exp_q.push_back({3'(i), e[i]});
        end
    endtask

    task automatic start_pass(input logic [1:0] sel);
        @(posedge clk);
        #1 start = 1'b1;
        layer_sel = sel;
        exp_layer = sel;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        automatic bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1'b1);
        @(negedge clk);
        check("idle_after_done", {engine_busy, done}, 2'b00);
    endtask

    task automatic check_counts(input int i0, input int c0, input int r0);
        check("get_image_count", img_cnt - i0, 1);
        check("get_coeffs_count", coef_cnt - c0, 8);
        check("result_count", res_cnt - r0, 8);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check(name, {get_image, get_coeffs, layer, result_data, result_idx, result_valid, engine_busy, done}, '0);
    endtask

    initial begin
        automatic int i0, c0, r0;
        cs_a = '{cset(rep(8'd2), 8'd3, 4'd0), cset(48'h060504030201, 8'hFB, 4'd1),
                 cset(rep(8'hFF), 8'd0, 4'd0), cset(rep(8'd127), 8'd127, 4'd0),
                 cset(rep(8'd127), 8'd127, 4'd2), cset(rep(8'd0), 8'h80, 4'd0),
                 cset(rep(8'd0), 8'd100, 4'd0), cset(rep(8'h80), 8'd127, 4'd0)};
        ex_a = '{8'd15, 8'd8, 8'd0, 8'd255, 8'd222, 8'd0, 8'd100, 8'd0};
        cs_b = '{cset(rep(8'hFF), 8'd0, 4'd0), cset(rep(8'hFF), 8'd127, 4'd0),
                 cset(rep(8'd3), 8'd0, 4'd0), cset(rep(8'd5), 8'd0, 4'd0),
                 cset(rep(8'd5), 8'd0, 4'd1), cset(rep(8'd5), 8'd0, 4'd15),
                 cset(rep(8'd1), 8'hC4, 4'd0), cset(rep(8'd1), 8'hC5, 4'd0)};
        ex_b = '{8'd0, 8'd67, 8'd180, 8'd255, 8'd150, 8'd0, 8'd0, 8'd1};
        cs_c = '{cset(rep(8'd127), 8'd0, 4'd0), cset(rep(8'd127), 8'd0, 4'd10),
                 cset(rep(8'hFF), 8'd127, 4'd0), cset(rep(8'd1), 8'd0, 4'd3),
                 cset(rep(8'd1), 8'd0, 4'd8), cset(rep(8'd0), 8'd5, 4'd0),
                 cset(rep(8'h80), 8'd0, 4'd0), cset(rep(8'd1), 8'h80, 4'd0)};
        ex_c = '{8'd255, 8'd189, 8'd0, 8'd191, 8'd5, 8'd5, 8'd0, 8'd255};

        reset = 1'b1; start = 1'b0; layer_sel = 2'd0; hold_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk);
        #1 reset = 1'b0;

        // Pass A: image all 1, layer_sel changes mid-pass
        load_pass(rep(8'd1), cs_a, ex_a, 8);
        i0 = img_cnt; c0 = coef_cnt; r0 = res_cnt;
        start_pass(2'd1);
        repeat (20) @(posedge clk);
        #1 layer_sel = 2'd3;
        wait_done();
        check_counts(i0, c0, r0);

        // Pass B: bus busy when start arrives, plus a second start mid-pass
        load_pass(rep(8'd10), cs_b, ex_b, 8);
        i0 = img_cnt; c0 = coef_cnt; r0 = res_cnt;
        #1 hold_busy = 1'b1;
        start_pass(2'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("no_request_while_busy", img_cnt - i0, 0);
        @(posedge clk);
        #1 hold_busy = 1'b0;
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        layer_sel = 2'd0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        check_counts(i0, c0, r0);

        // Pass C: image all 255, saturation and large shifts
        load_pass(rep(8'd255), cs_c, ex_c, 8);
        i0 = img_cnt; c0 = coef_cnt; r0 = res_cnt;
        start_pass(2'd0);
        wait_done();
        check_counts(i0, c0, r0);

        // Pass D: reset during MAC of neuron 3
        load_pass(rep(8'd1), cs_a, ex_a, 3);
        start_pass(2'd3);
        begin
            automatic bit seen = 1'b0;
            for (int i = 0; i < 2000 && !seen; i++) begin
                @(negedge clk);
                if (result_valid && result_idx == 3'd2) seen = 1'b1;
            end
            check("reached_neuron2", seen, 1'b1);
        end
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_zero("reset_mid_mac");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_held");
        check("scoreboard_after_reset", exp_q.size(), 0);
        coef_q.delete();
        img_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;

        // Pass E: clean full pass after the aborted one
        load_pass(rep(8'd1), cs_a, ex_a, 8);
        i0 = img_cnt; c0 = coef_cnt; r0 = res_cnt;
        start_pass(2'd2);
        wait_done();
        check_counts(i0, c0, r0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
